vcmp_cr6_wb: RTL and testbench

Result-consumer end of the vector compare path in the vsfx unit. Accepts element masks produced by the compare units (vcmpequb/vcmpequh/vcmpequw, 32-bit vectors) over a valid/ready handshake. Checks that each mask is well-formed, derives the CR6 summary for record-form (Rc=1) compares, and presents register-file writeback through a two-stage pipeline with backpressure.

---
 rtl/vsfx_pkg.sv | 36 +++
 rtl/vmask_check.sv | 50 +++++
 rtl/vcmp_cr6_wb.sv | 127 ++++++++++++
 tb/tb_vcmp_cr6_wb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vsfx_pkg.sv
// Shared definitions for the vsfx vector compare path: esize codes, CR6 bit
// positions, the register-file writeback payload and a CR6 packing helper.
// The payload is sized for the widest supported vector; narrower users slice it.
package vsfx_pkg;

  // Element size encodings carried with every compare result
  localparam logic [1:0] ESIZE_B   = 2'd0;
  localparam logic [1:0] ESIZE_H   = 2'd1;
  localparam logic [1:0] ESIZE_W   = 2'd2;
  localparam logic [1:0] ESIZE_RSV = 2'd3;

  // CR6 field layout: {all_true, 0, all_false, 0}
  localparam int CR6_ALL_TRUE  = 3;
  localparam int CR6_ALL_FALSE = 1;

  // Upper bounds on vector width and register address width for the payload
  localparam int WB_VW_MAX = 128;
  localparam int WB_AW_MAX = 8;

  typedef struct packed {
    logic [WB_VW_MAX-1:0] data;
    logic [WB_AW_MAX-1:0] vt;
    logic                 cr6_we;
    logic [3:0]           cr6;
    logic                 err;
  } wb_t;

  function automatic logic [3:0] cr6_pack(input logic all_true, input logic all_false);
    logic [3:0] c;
    c                = 4'b0000;
    c[CR6_ALL_TRUE]  = all_true;
    c[CR6_ALL_FALSE] = all_false;
    return c;
  endfunction

endpackage

// File: rtl/vmask_check.sv
// Mask classifier: element-wise well-formedness plus all-ones / all-zeros.
// Latency: purely combinational.
// Backpressure: none (no state, no handshake).
// Ports: mask (VW) + esize (2) in; wellformed, all_true, all_false out.
// A reserved esize is reported as not well-formed.
module vmask_check
  import vsfx_pkg::*;
#(
  parameter int VW = 32
) (
  input  logic [VW-1:0] mask,
  input  logic [1:0]    esize,
  output logic          wellformed,
  output logic          all_true,
  output logic          all_false
);

  logic b_ok;
  logic h_ok;
  logic w_ok;

  // Each element must be uniform: either every bit set or every bit clear
  always_comb begin
    b_ok = 1'b1;
    h_ok = 1'b1;
    w_ok = 1'b1;
    for (int i = 0; i < VW / 8; i++) begin
      if (!(mask[i*8 +: 8] == 8'h00 || mask[i*8 +: 8] == 8'hFF)) b_ok = 1'b0;
    end
    for (int i = 0; i < VW / 16; i++) begin
      if (!(mask[i*16 +: 16] == 16'h0000 || mask[i*16 +: 16] == 16'hFFFF)) h_ok = 1'b0;
    end
    for (int i = 0; i < VW / 32; i++) begin
      if (!(mask[i*32 +: 32] == 32'h0000_0000 || mask[i*32 +: 32] == 32'hFFFF_FFFF)) w_ok = 1'b0;
    end
  end

  always_comb begin
    case (esize)
      ESIZE_B: wellformed = b_ok;
      ESIZE_H: wellformed = h_ok;
      ESIZE_W: wellformed = w_ok;
      default: wellformed = 1'b0;
    endcase
  end

  assign all_true  = &mask;
  assign all_false = ~|mask;

endmodule

// File: rtl/vcmp_cr6_wb.sv
// Vector compare writeback: capture mask (S1), classify and build CR6 (S2).
// Latency: 2 cycles accept-to-out_valid; 1 entry/cycle sustained.
// Backpressure: ready chains back from out_ready through S2 and S1; depth 2.
// Ports: in_* valid/ready compare result (mask, esize, rc, vt);
//        out_* valid/ready writeback (data, vt, cr6_we, cr6, err);
//        err_cnt saturating count of malformed entries loaded into S2.
module vcmp_cr6_wb
  import vsfx_pkg::*;
#(
  parameter int VW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VW-1:0]   in_mask,
  input  logic [1:0]      in_esize,
  input  logic            in_rc,
  input  logic [AW-1:0]   in_vt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VW-1:0]   out_data,
  output logic [AW-1:0]   out_vt,
  output logic            out_cr6_we,
  output logic [3:0]      out_cr6,
  output logic            out_err,
  output logic [CNTW-1:0] err_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // S1: raw capture
  logic          s1_v;
  logic [VW-1:0] s1_mask;
  logic [1:0]    s1_esize;
  logic          s1_rc;
  logic [AW-1:0] s1_vt;

  // S2: finished writeback payload
  logic s2_v;
  wb_t  s2_q;
  wb_t  s2_d;

  logic s1_free;
  logic s2_free;

  logic wellformed;
  logic all_true;
  logic all_false;

  // Ready depends only on stage valids and out_ready, never on in_valid
  assign s2_free  = !s2_v || out_ready;
  assign s1_free  = !s1_v || s2_free;
  assign in_ready = s1_free;

  vmask_check #(.VW(VW)) u_check (
    .mask       (s1_mask),
    .esize      (s1_esize),
    .wellformed (wellformed),
    .all_true   (all_true),
    .all_false  (all_false)
  );

  // Reserved esize is already folded into wellformed by the checker
  always_comb begin
    s2_d              = '0;
    s2_d.data[VW-1:0] = s1_mask;
    s2_d.vt[AW-1:0]   = s1_vt;
    s2_d.cr6_we       = s1_rc;
    s2_d.cr6          = cr6_pack(all_true, all_false);
    s2_d.err          = !wellformed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_mask  <= '0;
      s1_esize <= '0;
      s1_rc    <= 1'b0;
      s1_vt    <= '0;
    end else if (s1_free) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_mask  <= in_mask;
        s1_esize <= in_esize;
        s1_rc    <= in_rc;
        s1_vt    <= in_vt;
      end
    end
  end

  // S2 payload only changes on a real load, so outputs hold after draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_q    <= '0;
      err_cnt <= '0;
    end else if (s2_free) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_q <= s2_d;
        if (s2_d.err && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

  assign out_valid  = s2_v;
  assign out_data   = s2_q.data[VW-1:0];
  assign out_vt     = s2_q.vt[AW-1:0];
  assign out_cr6_we = s2_q.cr6_we;
  assign out_cr6    = s2_q.cr6;
  assign out_err    = s2_q.err;

  // Payload headroom above the configured widths is constant zero
  if (VW < WB_VW_MAX) begin : g_data_pad
    logic unused_data_pad;
    assign unused_data_pad = ^s2_q.data[WB_VW_MAX-1:VW];
  end
  if (AW < WB_AW_MAX) begin : g_vt_pad
    logic unused_vt_pad;
    assign unused_vt_pad = ^s2_q.vt[WB_AW_MAX-1:AW];
  end

endmodule

// File: tb/tb_vcmp_cr6_wb.sv
module tb_vcmp_cr6_wb;

  localparam int VW   = 32;
  localparam int AW   = 5;
  localparam int CNTW = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   in_mask;
  logic [1:0]      in_esize;
  logic            in_rc;
  logic [AW-1:0]   in_vt;
  logic            out_valid;
  logic            out_ready;
  logic [VW-1:0]   out_data;
  logic [AW-1:0]   out_vt;
  logic            out_cr6_we;
  logic [3:0]      out_cr6;
  logic            out_err;
  logic [CNTW-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  vcmp_cr6_wb #(.VW(VW), .AW(AW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_esize   (in_esize),
    .in_rc      (in_rc),
    .in_vt      (in_vt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_vt     (out_vt),
    .out_cr6_we (out_cr6_we),
    .out_cr6    (out_cr6),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; checks then see post-edge state
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] m, input logic [1:0] es,
                       input logic rc, input logic [4:0] vt);
    in_valid = v;
    in_mask  = m;
    in_esize = es;
    in_rc    = rc;
    in_vt    = vt;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);

    // Reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_vt", {27'b0, out_vt}, 32'd0);
    chk("rst_cr6_we", {31'b0, out_cr6_we}, 32'd0);
    chk("rst_cr6", {28'b0, out_cr6}, 32'd0);
    chk("rst_err", {31'b0, out_err}, 32'd0);
    chk("rst_err_cnt", {30'b0, err_cnt}, 32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic halfword, latency 2
    out_ready = 1'b1;
    drive(1'b1, 32'h0000FFFF, 2'd1, 1'b1, 5'd3);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    chk("basic_n1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_data", out_data, 32'h0000FFFF);
    chk("basic_vt", {27'b0, out_vt}, 32'd3);
    chk("basic_cr6", {28'b0, out_cr6}, 32'h0);
    chk("basic_cr6_we", {31'b0, out_cr6_we}, 32'd1);
    chk("basic_err", {31'b0, out_err}, 32'd0);

    // All-true then all-false, back to back
    drive(1'b1, 32'hFFFFFFFF, 2'd1, 1'b1, 5'd4);
    tick();
    drive(1'b1, 32'h00000000, 2'd1, 1'b1, 5'd5);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    chk("at_valid", {31'b0, out_valid}, 32'd1);
    chk("at_cr6", {28'b0, out_cr6}, 32'h8);
    tick();
    chk("af_valid", {31'b0, out_valid}, 32'd1);
    chk("af_cr6", {28'b0, out_cr6}, 32'h2);
    chk("af_vt", {27'b0, out_vt}, 32'd5);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_cr6", {28'b0, out_cr6}, 32'h2);
    chk("hold_vt", {27'b0, out_vt}, 32'd5);

    // Malformed halfword mask, then same mask as bytes
    drive(1'b1, 32'h000000FF, 2'd1, 1'b1, 5'd6);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    tick();
    chk("mal_err", {31'b0, out_err}, 32'd1);
    chk("mal_err_cnt", {30'b0, err_cnt}, 32'd1);
    chk("mal_cr6", {28'b0, out_cr6}, 32'h0);
    drive(1'b1, 32'h000000FF, 2'd0, 1'b1, 5'd7);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    tick();
    chk("byte_err", {31'b0, out_err}, 32'd0);
    chk("byte_cr6", {28'b0, out_cr6}, 32'h0);
    chk("byte_err_cnt", {30'b0, err_cnt}, 32'd1);
    tick();
    chk("pre_bp_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: depth exactly 2, order preserved
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 2'd2, 1'b0, 5'd1);
    chk("bp_rdy0", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 32'h0, 2'd2, 1'b0, 5'd2);
    chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 32'h0, 2'd2, 1'b0, 5'd3);
    chk("bp_rdy_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head_vt", {27'b0, out_vt}, 32'd1);
    tick();
    chk("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
    chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_hold_vt", {27'b0, out_vt}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    chk("bp_out2_vt", {27'b0, out_vt}, 32'd2);
    chk("bp_out2_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_out3_vt", {27'b0, out_vt}, 32'd3);
    chk("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Reset mid-flight with two malformed entries pending
    out_ready = 1'b0;
    drive(1'b1, 32'h000000FF, 2'd2, 1'b1, 5'd8);
    tick();
    drive(1'b1, 32'h000000FF, 2'd2, 1'b1, 5'd9);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    chk("mid_err_cnt", {30'b0, err_cnt}, 32'd2);
    chk("mid_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_err_cnt", {30'b0, err_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_wb", {31'b0, out_valid}, 32'd0);
    end

    // Saturation: five malformed rc=0 entries streamed back to back
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000FF00, 2'd1, 1'b0, 5'(10 + i));
      tick();
      chk("sat_cnt_step", {30'b0, err_cnt}, (i < 3) ? i : 3);
    end
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    tick();
    chk("sat_cnt", {30'b0, err_cnt}, 32'd3);
    chk("sat_cr6_we", {31'b0, out_cr6_we}, 32'd0);
    chk("sat_err", {31'b0, out_err}, 32'd1);
    chk("sat_vt", {27'b0, out_vt}, 32'd14);

    // Reserved esize: err forced, cr6 still computed, cnt stays saturated
    drive(1'b1, 32'hFFFFFFFF, 2'd3, 1'b1, 5'd20);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0);
    tick();
    chk("rsv_err", {31'b0, out_err}, 32'd1);
    chk("rsv_cr6", {28'b0, out_cr6}, 32'h8);
    chk("rsv_cr6_we", {31'b0, out_cr6_we}, 32'd1);
    chk("rsv_cnt", {30'b0, err_cnt}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
